reg_writeback: RTL

- Write-side companion to the 8x16 register file: collects results from the ALU and load paths, queues them, and drives the regfile write port (write_en/wreg/writedata) at one write per cycle.
- Keeps a pending-write scoreboard so decode can stall on registers that still have a write outstanding.
- Sits between execute/memory and the register file; it is the only agent that writes the regfile.

---
 rtl/reg_writeback.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: write-side companion to the 8x16 register file.
// Collects ALU and load results and queues them in a small FIFO. It drives the
// regfile write port at one write per cycle. It also keeps a pending-write
// scoreboard that decode uses to stall on registers with a write outstanding.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_reg/ld_data       load result handshake (priority path)
//   alu_valid/alu_ready/alu_reg/alu_data   ALU result handshake
//   issue_en/issue_reg             decode issued a writer to issue_reg
//   write_en/wreg/writedata        registered regfile write port
//   pending                        bit i set: write to register i outstanding
//   busy                           queue non-empty or a write in progress
//
// Optional build macro REG_WRITEBACK_R0_ZERO_EN: register 0 is hardwired to zero.
// Results to r0 complete the handshake but are dropped, and pending[0] stays 0.
module reg_writeback #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [AW-1:0]        ld_reg,
    input  logic [DW-1:0]        ld_data,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_reg,
    input  logic [DW-1:0]        alu_data,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_reg,
    output logic                 write_en,
    output logic [AW-1:0]        wreg,
    output logic [DW-1:0]        writedata,
    output logic [(1<<AW)-1:0]   pending,
    output logic                 busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << AW;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [AW-1:0]   reg_mem  [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];

    logic [PW:0]     count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            write_en_q;
    logic [AW-1:0]   wreg_q;
    logic [DW-1:0]   writedata_q;
    logic [NREG-1:0] pending_q, pending_d;

    logic            push_ld, push_alu, push_en, pop, push_keep, issue_keep;
    logic [AW-1:0]   push_reg;
    logic [DW-1:0]   push_data;

    // Ready uses the pre-edge count, so a full queue refuses even on a pop cycle.
    assign ld_ready  = !rst && (count_q < DEPTH_C);
    assign alu_ready = !rst && (count_q < DEPTH_C) && !ld_valid;

    assign push_ld   = ld_valid && ld_ready;
    assign push_alu  = alu_valid && alu_ready;
    assign push_reg  = push_ld ? ld_reg  : alu_reg;
    assign push_data = push_ld ? ld_data : alu_data;

`ifdef REG_WRITEBACK_R0_ZERO_EN
    assign push_keep  = (push_reg != '0);
    assign issue_keep = (issue_reg != '0);
`else
    assign push_keep  = 1'b1;
    assign issue_keep = 1'b1;
`endif

    assign push_en = (push_ld || push_alu) && push_keep;
    assign pop     = (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Clear on the regfile write edge, then set; a same-edge set wins.
    always_comb begin
        pending_d = pending_q;
        if (write_en_q) begin
            pending_d[wreg_q] = 1'b0;
        end
        if (issue_en && issue_keep) begin
            pending_d[issue_reg] = 1'b1;
        end
`ifdef REG_WRITEBACK_R0_ZERO_EN
        pending_d[0] = 1'b0;
`endif
    end

    // Queue storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_en) begin
            reg_mem[wr_ptr_q]  <= push_reg;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            write_en_q  <= 1'b0;
            wreg_q      <= '0;
            writedata_q <= '0;
            pending_q   <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                write_en_q  <= 1'b1;
                wreg_q      <= reg_mem[rd_ptr_q];
                writedata_q <= data_mem[rd_ptr_q];
            end else begin
                write_en_q  <= 1'b0;
            end
        end
    end

    assign write_en  = write_en_q;
    assign wreg      = wreg_q;
    assign writedata = writedata_q;
    assign pending   = pending_q;
    assign busy      = (count_q != '0) || write_en_q;

endmodule
